// File: rtl/can_fault_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : can_fault_ctrl
// Purpose  : CAN error/overload frame sequencer with TEC/REC fault confinement.
// Revision : 1.0
// ============================================================================
module can_fault_ctrl #(
    parameter int FLAG_LEN         = 6,
    parameter int DELIM_LEN        = 8,
    parameter int INTERMISSION_LEN = 3,
    parameter int PASSIVE_LIMIT    = 128,
    parameter int BUSOFF_LIMIT     = 256,
    parameter int RECOVERY_SEQ     = 128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       samplePoint,
    input  logic       canRX,
    input  logic       eofErro,
    input  logic       crcErro,
    input  logic       stuffErro,
    input  logic       bitErro,
    input  logic       ackErro,
    input  logic       overloadFlag,
    input  logic       frameDone,
    input  logic       isTransmitter,
    output logic       canTX,
    output logic       erro,
    output logic       interframe,
    output logic [1:0] errState,
    output logic [8:0] tec,
    output logic [7:0] rec
);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ERR_FLAG  = 4'd1,
        S_ERR_WAIT  = 4'd2,
        S_ERR_DELIM = 4'd3,
        S_OVL_FLAG  = 4'd4,
        S_OVL_WAIT  = 4'd5,
        S_OVL_DELIM = 4'd6,
        S_INTER     = 4'd7,
        S_BUS_OFF   = 4'd8
    } state_t;

    localparam logic [3:0] c_FLAG_LAST  = 4'(FLAG_LEN - 1);
    localparam logic [3:0] c_DELIM_LAST = 4'(DELIM_LEN - 1);
    localparam logic [3:0] c_INTER_LAST = 4'(INTERMISSION_LEN - 1);
    localparam logic [3:0] c_RUN_LAST   = 4'd10;
    localparam logic [7:0] c_SEQ_LAST   = 8'(RECOVERY_SEQ - 1);
    localparam logic [8:0] c_PASS_TEC   = 9'(PASSIVE_LIMIT);
    localparam logic [7:0] c_PASS_REC   = 8'(PASSIVE_LIMIT);
    localparam logic [8:0] c_BUSOFF     = 9'(BUSOFF_LIMIT);
    localparam logic [7:0] c_REC_RESUME = 8'd120;

    state_t     r_state;
    logic [3:0] r_cnt;
    logic [3:0] r_run;
    logic [7:0] r_seq;
    logic [8:0] r_tec;
    logic [7:0] r_rec;
    logic       r_canTX;
    logic       r_erro;
    logic       r_interframe;

    state_t     w_state_nx;
    logic [3:0] w_cnt_nx;
    logic [3:0] w_run_nx;
    logic [7:0] w_seq_nx;
    logic [8:0] w_tec_nx;
    logic [7:0] w_rec_nx;
    logic       w_canTX_nx;
    logic       w_erro_nx;
    logic       w_interframe_nx;
    logic       w_passive_nx;
    logic       w_any_err;

    assign w_any_err = ~(eofErro & crcErro & stuffErro & bitErro & ackErro);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_run        <= 4'd0;
            r_seq        <= 8'd0;
            r_tec        <= 9'd0;
            r_rec        <= 8'd0;
            r_canTX      <= 1'b1;
            r_erro       <= 1'b1;
            r_interframe <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_run        <= w_run_nx;
            r_seq        <= w_seq_nx;
            r_tec        <= w_tec_nx;
            r_rec        <= w_rec_nx;
            r_canTX      <= w_canTX_nx;
            r_erro       <= w_erro_nx;
            r_interframe <= w_interframe_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_run_nx   = r_run;
        w_seq_nx   = r_seq;
        w_tec_nx   = r_tec;
        w_rec_nx   = r_rec;
        if (samplePoint) begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_err) begin
                        w_state_nx = S_ERR_FLAG;
                        w_cnt_nx   = 4'd0;
                        if (isTransmitter)
                            w_tec_nx = (r_tec > 9'd503) ? 9'd511 : r_tec + 9'd8;
                        else
                            w_rec_nx = (r_rec == 8'd255) ? 8'd255 : r_rec + 8'd1;
                    end else if (!overloadFlag) begin
                        w_state_nx = S_OVL_FLAG;
                        w_cnt_nx   = 4'd0;
                    end else if (frameDone) begin
                        w_state_nx = S_INTER;
                        w_cnt_nx   = 4'd0;
                        if (isTransmitter) begin
                            if (r_tec != 9'd0)
                                w_tec_nx = r_tec - 9'd1;
                        end else if (r_rec >= c_PASS_REC) begin
                            w_rec_nx = c_REC_RESUME;
                        end else if (r_rec != 8'd0) begin
                            w_rec_nx = r_rec - 8'd1;
                        end
                    end
                end
                S_ERR_FLAG, S_OVL_FLAG: begin
                    if (r_cnt == c_FLAG_LAST) begin
                        w_state_nx = (r_state == S_ERR_FLAG) ? S_ERR_WAIT : S_OVL_WAIT;
                        w_cnt_nx   = 4'd0;
                    end else begin
                        w_cnt_nx = r_cnt + 4'd1;
                    end
                end
                S_ERR_WAIT, S_OVL_WAIT: begin
                    // The recessive bit that ends the wait is delimiter bit one.
                    if (canRX) begin
                        w_state_nx = (r_state == S_ERR_WAIT) ? S_ERR_DELIM : S_OVL_DELIM;
                        w_cnt_nx   = 4'd1;
                    end
                end
                S_ERR_DELIM, S_OVL_DELIM: begin
                    if (r_cnt == c_DELIM_LAST) begin
                        w_cnt_nx = 4'd0;
                        if (!canRX) begin
                            w_state_nx = S_OVL_FLAG;
                        end else if (r_state == S_ERR_DELIM && r_tec >= c_BUSOFF) begin
                            w_state_nx = S_BUS_OFF;
                            w_run_nx   = 4'd0;
                            w_seq_nx   = 8'd0;
                        end else begin
                            w_state_nx = S_INTER;
                        end
                    end else begin
                        w_cnt_nx = r_cnt + 4'd1;
                    end
                end
                S_INTER: begin
                    // Dominant on the last bit is a start-of-frame, not an overload.
                    if (r_cnt == c_INTER_LAST) begin
                        w_state_nx = S_IDLE;
                        w_cnt_nx   = 4'd0;
                    end else if (!canRX) begin
                        w_state_nx = S_OVL_FLAG;
                        w_cnt_nx   = 4'd0;
                    end else begin
                        w_cnt_nx = r_cnt + 4'd1;
                    end
                end
                S_BUS_OFF: begin
                    if (!canRX) begin
                        w_run_nx = 4'd0;
                    end else if (r_run == c_RUN_LAST) begin
                        w_run_nx = 4'd0;
                        if (r_seq == c_SEQ_LAST) begin
                            w_state_nx = S_IDLE;
                            w_seq_nx   = 8'd0;
                            w_tec_nx   = 9'd0;
                            w_rec_nx   = 8'd0;
                        end else begin
                            w_seq_nx = r_seq + 8'd1;
                        end
                    end else begin
                        w_run_nx = r_run + 4'd1;
                    end
                end
                default: begin
                    w_state_nx = S_IDLE;
                    w_cnt_nx   = 4'd0;
                end
            endcase
        end
    end

    // Registered outputs follow the state and counters being entered, so a
    // flag sent right after crossing the passive limit is already recessive.
    always_comb begin
        w_passive_nx    = (w_tec_nx >= c_PASS_TEC) || (w_rec_nx >= c_PASS_REC);
        w_canTX_nx      = ~((w_state_nx == S_OVL_FLAG) ||
                            ((w_state_nx == S_ERR_FLAG) && !w_passive_nx));
        w_erro_nx       = (w_state_nx != S_ERR_FLAG);
        w_interframe_nx = (w_state_nx == S_INTER);
    end

    always_comb begin
        if (r_state == S_BUS_OFF)
            errState = 2'b10;
        else if ((r_tec >= c_PASS_TEC) || (r_rec >= c_PASS_REC))
            errState = 2'b01;
        else
            errState = 2'b00;
    end

    assign canTX      = r_canTX;
    assign erro       = r_erro;
    assign interframe = r_interframe;
    assign tec        = r_tec;
    assign rec        = r_rec;

endmodule
`default_nettype wire

// File: tb/tb_can_fault_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_can_fault_ctrl
// Purpose  : Directed self-checking bench for can_fault_ctrl.
// Revision : 1.0
// ============================================================================
module tb_can_fault_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       samplePoint = 1'b0;
    logic       canRX = 1'b1;
    logic       eofErro = 1'b1;
    logic       crcErro = 1'b1;
    logic       stuffErro = 1'b1;
    logic       bitErro = 1'b1;
    logic       ackErro = 1'b1;
    logic       overloadFlag = 1'b1;
    logic       frameDone = 1'b0;
    logic       isTransmitter = 1'b0;
    logic       canTX;
    logic       erro;
    logic       interframe;
    logic [1:0] errState;
    logic [8:0] tec;
    logic [7:0] rec;

    int passed = 0;
    int total  = 0;

    can_fault_ctrl dut (
        .clock(clock), .reset(reset), .samplePoint(samplePoint), .canRX(canRX),
        .eofErro(eofErro), .crcErro(crcErro), .stuffErro(stuffErro),
        .bitErro(bitErro), .ackErro(ackErro), .overloadFlag(overloadFlag),
        .frameDone(frameDone), .isTransmitter(isTransmitter), .canTX(canTX),
        .erro(erro), .interframe(interframe), .errState(errState),
        .tec(tec), .rec(rec)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    // One bit time: a sample-point cycle followed by an idle cycle.
    task automatic bit_step();
        samplePoint = 1'b1;
        @(posedge clock); #1;
        samplePoint = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic do_reset();
        eofErro = 1'b1; crcErro = 1'b1; stuffErro = 1'b1; bitErro = 1'b1;
        ackErro = 1'b1; overloadFlag = 1'b1; frameDone = 1'b0; canRX = 1'b1;
        samplePoint = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1;
    endtask

    task automatic finish_error_frame();
        canRX = 1'b0;
        repeat (6) bit_step();
        canRX = 1'b1;
        repeat (11) bit_step();
    endtask

    task automatic error_frame();
        bitErro = 1'b0; bit_step(); bitErro = 1'b1;
        finish_error_frame();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (canTX !== 1'b1) $display("FAIL reset_canTX: got %b want 1", canTX); else passed++;
        total++; if (erro !== 1'b1) $display("FAIL reset_erro: got %b want 1", erro); else passed++;
        total++; if (interframe !== 1'b0) $display("FAIL reset_interframe: got %b want 0", interframe); else passed++;
        total++; if (errState !== 2'b00) $display("FAIL reset_errState: got %b want 00", errState); else passed++;
        total++; if (tec !== 9'd0 || rec !== 8'd0) $display("FAIL reset_counters: got tec=%0d rec=%0d want 0 0", tec, rec); else passed++;
        // Strobe without a sample point must be ignored.
        bitErro = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        bitErro = 1'b1;
        total++; if (erro !== 1'b1 || rec !== 8'd0) $display("FAIL no_sample_gate: got erro=%b rec=%0d want 1 0", erro, rec); else passed++;
    endtask

    task automatic test_active_receiver();
        int bad;
        do_reset();
        isTransmitter = 1'b0;
        stuffErro = 1'b0; bit_step(); stuffErro = 1'b1;
        total++; if (rec !== 8'd1) $display("FAIL rx_rec_inc: got %0d want 1", rec); else passed++;
        total++; if (canTX !== 1'b0 || erro !== 1'b0) $display("FAIL rx_flag_start: got canTX=%b erro=%b want 0 0", canTX, erro); else passed++;
        canRX = 1'b0;
        bad = 0;
        repeat (5) begin bit_step(); if (canTX !== 1'b0 || erro !== 1'b0) bad++; end
        total++; if (bad !== 0) $display("FAIL rx_flag_bits: got %0d bad bits want 0", bad); else passed++;
        bit_step();
        total++; if (canTX !== 1'b1 || erro !== 1'b1) $display("FAIL rx_flag_end: got canTX=%b erro=%b want 1 1", canTX, erro); else passed++;
        repeat (2) bit_step();
        total++; if (canTX !== 1'b1 || interframe !== 1'b0) $display("FAIL rx_wait: got canTX=%b interframe=%b want 1 0", canTX, interframe); else passed++;
        canRX = 1'b1;
        bad = 0;
        for (int i = 1; i <= 7; i++) begin bit_step(); if (interframe !== 1'b0) bad++; end
        total++; if (bad !== 0) $display("FAIL rx_delim_len: got %0d early interframe want 0", bad); else passed++;
        bit_step();
        total++; if (interframe !== 1'b1) $display("FAIL rx_inter_start: got %b want 1", interframe); else passed++;
        bad = 0;
        repeat (2) begin bit_step(); if (interframe !== 1'b1) bad++; end
        total++; if (bad !== 0) $display("FAIL rx_inter_len: got %0d short bits want 0", bad); else passed++;
        bit_step();
        total++; if (interframe !== 1'b0 || canTX !== 1'b1) $display("FAIL rx_back_idle: got interframe=%b canTX=%b want 0 1", interframe, canTX); else passed++;
    endtask

    task automatic test_passive_tx();
        int bad;
        do_reset();
        isTransmitter = 1'b1;
        repeat (15) error_frame();
        total++; if (tec !== 9'd120 || errState !== 2'b00) $display("FAIL tx_tec120: got tec=%0d st=%b want 120 00", tec, errState); else passed++;
        error_frame();
        total++; if (tec !== 9'd128 || errState !== 2'b01) $display("FAIL tx_passive: got tec=%0d st=%b want 128 01", tec, errState); else passed++;
        bitErro = 1'b0; bit_step(); bitErro = 1'b1;
        total++; if (tec !== 9'd136 || canTX !== 1'b1 || erro !== 1'b0) $display("FAIL tx_passive_flag: got tec=%0d canTX=%b erro=%b want 136 1 0", tec, canTX, erro); else passed++;
        canRX = 1'b0;
        bad = 0;
        repeat (5) begin bit_step(); if (canTX !== 1'b1 || erro !== 1'b0) bad++; end
        total++; if (bad !== 0) $display("FAIL tx_passive_bits: got %0d bad bits want 0", bad); else passed++;
        bit_step();
        canRX = 1'b1;
        repeat (11) bit_step();
    endtask

    task automatic test_busoff();
        do_reset();
        isTransmitter = 1'b1;
        repeat (31) error_frame();
        total++; if (tec !== 9'd248) $display("FAIL bo_tec248: got %0d want 248", tec); else passed++;
        bitErro = 1'b0; bit_step(); bitErro = 1'b1;
        canRX = 1'b0; repeat (6) bit_step();
        canRX = 1'b1; repeat (8) bit_step();
        total++; if (tec !== 9'd256 || errState !== 2'b10) $display("FAIL bo_enter: got tec=%0d st=%b want 256 10", tec, errState); else passed++;
        repeat (5) bit_step();
        canRX = 1'b0; bitErro = 1'b0; overloadFlag = 1'b0;
        bit_step();
        bitErro = 1'b1; overloadFlag = 1'b1; canRX = 1'b1;
        total++; if (canTX !== 1'b1 || erro !== 1'b1 || tec !== 9'd256) $display("FAIL bo_ignore: got canTX=%b erro=%b tec=%0d want 1 1 256", canTX, erro, tec); else passed++;
        repeat (128 * 11 - 1) bit_step();
        total++; if (errState !== 2'b10) $display("FAIL bo_not_yet: got %b want 10", errState); else passed++;
        bit_step();
        total++; if (tec !== 9'd0 || rec !== 8'd0 || errState !== 2'b00) $display("FAIL bo_recover: got tec=%0d rec=%0d st=%b want 0 0 00", tec, rec, errState); else passed++;
        isTransmitter = 1'b0;
        frameDone = 1'b1; bit_step(); frameDone = 1'b0;
        total++; if (interframe !== 1'b1) $display("FAIL bo_idle: got interframe=%b want 1", interframe); else passed++;
        repeat (3) bit_step();
    endtask

    task automatic test_overload_intermission();
        int bad;
        do_reset();
        isTransmitter = 1'b0;
        frameDone = 1'b1; bit_step(); frameDone = 1'b0;
        total++; if (interframe !== 1'b1) $display("FAIL ovl_inter_entry: got %b want 1", interframe); else passed++;
        canRX = 1'b1; bit_step();
        canRX = 1'b0; bit_step();
        total++; if (canTX !== 1'b0 || erro !== 1'b1 || interframe !== 1'b0) $display("FAIL ovl_flag_start: got canTX=%b erro=%b if=%b want 0 1 0", canTX, erro, interframe); else passed++;
        bad = 0;
        repeat (5) begin bit_step(); if (canTX !== 1'b0) bad++; end
        total++; if (bad !== 0) $display("FAIL ovl_flag_bits: got %0d bad bits want 0", bad); else passed++;
        bit_step();
        total++; if (canTX !== 1'b1) $display("FAIL ovl_flag_end: got %b want 1", canTX); else passed++;
        canRX = 1'b1;
        repeat (8) bit_step();
        total++; if (interframe !== 1'b1) $display("FAIL ovl_delim_done: got %b want 1", interframe); else passed++;
        bit_step(); bit_step();
        canRX = 1'b0; bit_step();
        total++; if (interframe !== 1'b0 || canTX !== 1'b1) $display("FAIL sof_on_bit3: got if=%b canTX=%b want 0 1", interframe, canTX); else passed++;
        canRX = 1'b1; bit_step();
        total++; if (canTX !== 1'b1 || erro !== 1'b1 || interframe !== 1'b0) $display("FAIL sof_idle: got canTX=%b erro=%b if=%b want 1 1 0", canTX, erro, interframe); else passed++;
    endtask

    task automatic test_priority();
        do_reset();
        isTransmitter = 1'b0;
        crcErro = 1'b0; overloadFlag = 1'b0; frameDone = 1'b1;
        bit_step();
        crcErro = 1'b1; overloadFlag = 1'b1; frameDone = 1'b0;
        total++; if (erro !== 1'b0 || rec !== 8'd1 || canTX !== 1'b0) $display("FAIL prio_err: got erro=%b rec=%0d canTX=%b want 0 1 0", erro, rec, canTX); else passed++;
        finish_error_frame();
        overloadFlag = 1'b0; frameDone = 1'b1; bit_step();
        overloadFlag = 1'b1; frameDone = 1'b0;
        total++; if (canTX !== 1'b0 || erro !== 1'b1 || interframe !== 1'b0 || rec !== 8'd1) $display("FAIL prio_ovl: got canTX=%b erro=%b if=%b rec=%0d want 0 1 0 1", canTX, erro, interframe, rec); else passed++;
        canRX = 1'b0; repeat (6) bit_step();
        canRX = 1'b1; repeat (11) bit_step();
    endtask

    task automatic test_rec_recovery();
        do_reset();
        isTransmitter = 1'b0;
        repeat (130) error_frame();
        total++; if (rec !== 8'd130 || errState !== 2'b01) $display("FAIL rec130: got rec=%0d st=%b want 130 01", rec, errState); else passed++;
        frameDone = 1'b1; bit_step(); frameDone = 1'b0;
        total++; if (rec !== 8'd120 || errState !== 2'b00) $display("FAIL rec_resume: got rec=%0d st=%b want 120 00", rec, errState); else passed++;
        repeat (3) bit_step();
        frameDone = 1'b1; bit_step(); frameDone = 1'b0;
        total++; if (rec !== 8'd119) $display("FAIL rec_dec: got %0d want 119", rec); else passed++;
        repeat (3) bit_step();
        isTransmitter = 1'b1;
        frameDone = 1'b1; bit_step(); frameDone = 1'b0;
        total++; if (tec !== 9'd0 || rec !== 8'd119) $display("FAIL tec_floor: got tec=%0d rec=%0d want 0 119", tec, rec); else passed++;
        repeat (3) bit_step();
    endtask

    task automatic test_reset_midflag();
        do_reset();
        isTransmitter = 1'b1;
        bitErro = 1'b0; bit_step(); bitErro = 1'b1;
        canRX = 1'b0;
        bit_step(); bit_step();
        total++; if (tec !== 9'd8 || canTX !== 1'b0) $display("FAIL midflag_pre: got tec=%0d canTX=%b want 8 0", tec, canTX); else passed++;
        #2 reset = 1'b0;
        #1;
        total++; if (canTX !== 1'b1 || erro !== 1'b1 || tec !== 9'd0 || rec !== 8'd0) $display("FAIL midflag_reset: got canTX=%b erro=%b tec=%0d rec=%0d want 1 1 0 0", canTX, erro, tec, rec); else passed++;
        @(posedge clock); #1 reset = 1'b1;
        canRX = 1'b1;
        bit_step();
        total++; if (canTX !== 1'b1 || erro !== 1'b1) $display("FAIL midflag_idle: got canTX=%b erro=%b want 1 1", canTX, erro); else passed++;
    endtask

    initial begin
        test_reset();
        test_active_receiver();
        test_passive_tx();
        test_busoff();
        test_overload_intermission();
        test_priority();
        test_rec_recovery();
        test_reset_midflag();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/can_fault_ctrl.md
Name: can_fault_ctrl

Overview:
- Sequences CAN error frames, overload frames and intermission, driven by the error-detector strobes from the bit-stream logic.
- Maintains the transmit and receive error counters and the fault-confinement state: error-active, error-passive or bus-off.
- Sits between the error-detection flags and the TX bit driver.
- All bit-level decisions are taken only on cycles where samplePoint=1; samplePoint is a one-clock enable pulse per bit time.

Parameters:
- FLAG_LEN, 6, bits in an error or overload flag.
- DELIM_LEN, 8, recessive bits in a delimiter, including the first recessive bit seen.
- INTERMISSION_LEN, 3, intermission bits.
- PASSIVE_LIMIT, 128, TEC/REC threshold for error-passive.
- BUSOFF_LIMIT, 256, TEC threshold for bus-off.
- RECOVERY_SEQ, 128, number of 11-recessive-bit sequences needed to leave bus-off.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- samplePoint  in  1  one-cycle bit sample strobe.
- canRX  in  1  sampled bus level (0 = dominant).
- eofErro, crcErro, stuffErro, bitErro, ackErro  in  1 each  error strobes, active-low.
- overloadFlag  in  1  overload request, active-low.
- frameDone  in  1  high at the sample point of the last EOF bit of a good frame.
- isTransmitter  in  1  node is the transmitter of the current frame.
- canTX  out  1  bit to drive (1 = recessive).
- erro  out  1  active-low; 0 while the error flag is being sent.
- interframe  out  1  1 during intermission.
- errState  out  2  00 active, 01 passive, 10 bus-off.
- tec  out  9  transmit error counter.
- rec  out  8  receive error counter.

Behaviour:
- Reset values: state IDLE, canTX=1, erro=1, interframe=0, errState=00, tec=0, rec=0, all internal counters 0. Reset asserted mid-frame aborts immediately to these values.
- All state, counter and output changes occur on the clock edge of a samplePoint cycle. Outputs are registered and take effect for the next bit.

State machine:
- IDLE: canTX=1.
  - Any error strobe low → ERR_FLAG.
  - Otherwise overloadFlag low → OVL_FLAG.
  - Otherwise frameDone=1 → INTERMISSION.
  - Error has priority over overload, and overload over frameDone.
- ERR_FLAG: counts FLAG_LEN bits.
  - canTX=0 if errState=00; canTX=1 if passive.
  - erro=0 throughout.
  - Then → ERR_WAIT.
- ERR_WAIT: canTX=1; stays until canRX=1 is sampled, then → ERR_DELIM with the bit count set to 1.
- ERR_DELIM: counts to DELIM_LEN recessive bits.
  - Dominant sampled on the final delimiter bit → OVL_FLAG.
  - On completion: tec≥BUSOFF_LIMIT → BUS_OFF; otherwise → INTERMISSION.
- OVL_FLAG: canTX=0 for FLAG_LEN bits, then → OVL_WAIT.
- OVL_WAIT / OVL_DELIM: same as ERR_WAIT / ERR_DELIM, except completion always → INTERMISSION.
- INTERMISSION: interframe=1 for INTERMISSION_LEN bits.
  - Dominant sampled on bits 1..2 → OVL_FLAG.
  - Dominant on the last bit → IDLE (treated as SOF).
  - Completion → IDLE.
- BUS_OFF: canTX=1; error and overload strobes are ignored.
  - Counts consecutive recessive samples; every 11th consecutive recessive sample increments the sequence counter and restarts the run.
  - A dominant sample restarts the run but keeps the sequence count.
  - At RECOVERY_SEQ sequences: tec=0, rec=0 → IDLE.

Counters:
- Entry to ERR_FLAG: if isTransmitter, tec+=8, saturating at 511; else rec+=1, saturating at 255.
- frameDone in IDLE:
  - If isTransmitter and tec>0: tec-=1.
  - If receiver: rec>127 → rec=120; else if rec>0: rec-=1.
- Error and overload strobes are ignored outside IDLE.

errState (combinational from the registered counters and state):
- 10 while in BUS_OFF.
- Else 01 if tec≥PASSIVE_LIMIT or rec≥PASSIVE_LIMIT.
- Else 00.

Test Plan:
- Error-active receiver: after reset, stuffErro=0 at one sample → rec=1, canTX=0 for 6 bits with erro=0, then ERR_WAIT. Drive canRX=1 → 8 recessive delimiter bits, 3 bits with interframe=1, then IDLE.
- Passive transmitter: preload to tec=128 via 16 transmit errors → errState=01. Next error flag drives canTX=1 for 6 bits.
- Bus-off: 32 transmit errors → tec=256, BUS_OFF after the delimiter, errState=10. Apply 128×11 recessive samples → tec=rec=0, errState=00, IDLE.
- Overload in intermission: dominant sampled on intermission bit 2 → canTX=0 for 6 bits. Dominant on bit 3 → IDLE with no flag.
- Priority: crcErro=0 and overloadFlag=0 on the same sample → ERR_FLAG taken and rec increments.
- Receiver recovery: rec=130, then frameDone with isTransmitter=0 → rec=120. Also: reset asserted during ERR_FLAG bit 3 → canTX=1, erro=1, tec=rec=0 immediately.
